// File: rtl/pe2ddr_wr_chan.sv
// DDR write channel: latches a transfer config, generates burst addresses and
// streams beats from one run-time selected source through a FWFT data FIFO.
module pe2ddr_wr_chan #(
  parameter int DDR_W      = 512,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8,
  parameter int SRC_NUM    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int SEL_W      = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [SEL_W-1:0]         conf_src_sel,
  input  logic [DDR_ADDR_W-1:0]    conf_st_addr,
  input  logic [BURST_W-1:0]       conf_burst,
  input  logic [DDR_ADDR_W-1:0]    conf_step,
  input  logic [BURST_W-1:0]       conf_burst_num,
  input  logic [SRC_NUM*DDR_W-1:0] src_data,
  input  logic [SRC_NUM-1:0]       src_valid,
  output logic [SRC_NUM-1:0]       src_ready,
  output logic [DDR_ADDR_W-1:0]    ddr_addr,
  output logic [BURST_W-1:0]       ddr_size,
  output logic                     ddr_addr_valid,
  input  logic                     ddr_addr_ready,
  output logic [DDR_W-1:0]         ddr_data,
  output logic                     ddr_valid,
  input  logic                     ddr_ready,
  output logic                     ddr_last,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 2 * BURST_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [SEL_W-1:0]      sel_q;
  logic [DDR_ADDR_W-1:0] addr_q, step_q;
  logic [BURST_W-1:0]    size_q, bnum_q, addr_cnt_q, beat_cnt_q;
  logic [CNT_W-1:0]      total_q, in_cnt_q, out_cnt_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        fifo_cnt_q;
  logic [DDR_W-1:0]      mem_q [FIFO_DEPTH];

  logic [CNT_W-1:0]      conf_total;
  logic                  run, accept_start, addr_fire, can_push, push, pop;
  logic                  sel_valid;
  logic [DDR_W-1:0]      sel_data;

  // Every channel uses valid/ready: a transfer happens on a cycle where both are
  // high; a producer holding valid keeps its payload stable until ready is seen.
  assign conf_total   = CNT_W'(conf_burst) * CNT_W'(conf_burst_num);
  assign run          = (state_q == S_RUN);
  assign accept_start = (state_q == S_IDLE) && start;
  assign addr_fire    = ddr_addr_valid && ddr_addr_ready;
  assign can_push     = run && (fifo_cnt_q != (PTR_W+1)'(FIFO_DEPTH)) && (in_cnt_q < total_q);
  assign push         = can_push && sel_valid;
  assign pop          = ddr_valid && ddr_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    src_ready = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_valid    = src_valid[i];
        sel_data     = src_data[i*DDR_W +: DDR_W];
        src_ready[i] = can_push;
      end
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign dbg_state      = state_q;
  assign ddr_addr_valid = run && (addr_cnt_q < bnum_q);
  assign ddr_addr       = addr_q;
  assign ddr_size       = size_q;
  assign ddr_valid      = (fifo_cnt_q != '0);
  assign ddr_data       = ddr_valid ? mem_q[rd_ptr_q] : '0;
  assign ddr_last       = ddr_valid && (beat_cnt_q == size_q - 1'b1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (conf_total == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if ((addr_cnt_q == bnum_q) && (in_cnt_q == total_q) && (out_cnt_q == total_q))
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      step_q     <= '0;
      size_q     <= '0;
      bnum_q     <= '0;
      total_q    <= '0;
      addr_cnt_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        sel_q      <= conf_src_sel;
        addr_q     <= conf_st_addr;
        step_q     <= conf_step;
        size_q     <= conf_burst;
        bnum_q     <= conf_burst_num;
        total_q    <= conf_total;
        addr_cnt_q <= '0;
        in_cnt_q   <= '0;
        out_cnt_q  <= '0;
        beat_cnt_q <= '0;
      end else begin
        // Running sum; wraps naturally at the address width.
        if (addr_fire) begin
          addr_cnt_q <= addr_cnt_q + 1'b1;
          addr_q     <= addr_q + step_q;
        end
        if (push) in_cnt_q <= in_cnt_q + 1'b1;
        if (pop) begin
          out_cnt_q  <= out_cnt_q + 1'b1;
          beat_cnt_q <= (beat_cnt_q == size_q - 1'b1) ? '0 : beat_cnt_q + 1'b1;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: ddr_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sel_data;
  end

endmodule
